// File: rtl/regfile_mp_sb_pkg.sv
// Shared constants and decode-facing typedefs for the multi-port register file.
package regfile_mp_sb_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_NUM_RD   = 2;
  localparam int RF_ZERO_IDX = 0;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;

  // Source operand pair as produced by the decode stage for the default two read ports.
  typedef struct packed {
    rf_addr_t rs;
    rf_addr_t rt;
  } rf_rd_req_t;

  typedef struct packed {
    rf_data_t rs_val;
    rf_data_t rt_val;
  } rf_rd_rsp_t;

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Decode/writeback-side bus of the register file; master drives addresses and writes.
interface regfile_mp_sb_if import regfile_mp_sb_pkg::*; #(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_RD = RF_NUM_RD
);

  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]        rbusy;
  logic                     wren;
  logic [ADDR_W-1:0]        waddr;
  logic [DATA_W-1:0]        wdata;
  logic                     alloc_en;
  logic [ADDR_W-1:0]        alloc_addr;
  logic                     flush;
  logic [ADDR_W:0]          busy_cnt;

  modport master (
    output raddr, wren, waddr, wdata, alloc_en, alloc_addr, flush,
    input  rdata, rbusy, busy_cnt
  );

  modport slave (
    input  raddr, wren, waddr, wdata, alloc_en, alloc_addr, flush,
    output rdata, rbusy, busy_cnt
  );

endinterface

// File: rtl/regfile_rd_port.sv
// One combinational read port: array mux, optional write bypass, hardwired-zero override.
module regfile_rd_port import regfile_mp_sb_pkg::*; #(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [ADDR_W-1:0]      raddr,
  input  logic [DATA_W-1:0]      regs [2**ADDR_W],
  input  logic [2**ADDR_W-1:0]   busy,
  input  logic                   wren,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      rdata,
  output logic                   rbusy
);

  // Zero-register override comes last so it also wins over a bypassed write to r0.
  always_comb begin
    rdata = regs[raddr];
    rbusy = busy[raddr];
    if (BYPASS != 0 && wren && waddr == raddr) begin
      rdata = wdata;
      rbusy = 1'b0;
    end
    if (ZERO_REG != 0 && raddr == ADDR_W'(RF_ZERO_IDX)) begin
      rdata = '0;
      rbusy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with async clear, zero register, bypass and busy scoreboard.
module regfile_mp_sb import regfile_mp_sb_pkg::*; #(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = RF_NUM_RD,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic            clk,
  input logic            rst_n,
  regfile_mp_sb_if.slave bus
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [ADDR_W:0]   busy_cnt_q;
  logic [ADDR_W:0]   cnt_nxt;
  logic              wr_ok;
  logic              alloc_ok;

  assign wr_ok    = bus.wren && !(ZERO_REG != 0 && bus.waddr == ADDR_W'(RF_ZERO_IDX));
  assign alloc_ok = bus.alloc_en && !(ZERO_REG != 0 && bus.alloc_addr == ADDR_W'(RF_ZERO_IDX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[bus.waddr] <= bus.wdata;
    end
  end

  // Ordering encodes priority: flush, then the retiring write, then a new allocation.
  always_comb begin
    busy_nxt = bus.flush ? '0 : busy;
    if (bus.wren) busy_nxt[bus.waddr] = 1'b0;
    if (alloc_ok) busy_nxt[bus.alloc_addr] = 1'b1;
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy       <= busy_nxt;
      busy_cnt_q <= cnt_nxt;
    end
  end

  assign bus.busy_cnt = busy_cnt_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_rd_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) u_rd (
      .raddr(bus.raddr[k*ADDR_W +: ADDR_W]),
      .regs (regs),
      .busy (busy),
      .wren (bus.wren),
      .waddr(bus.waddr),
      .wdata(bus.wdata),
      .rdata(bus.rdata[k*DATA_W +: DATA_W]),
      .rbusy(bus.rbusy[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench: default configuration plus a 4-port, 8-deep, no-zero, no-bypass variant.
module tb_regfile_mp_sb;

  logic clk;
  logic rst_n;

  regfile_mp_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus_a ();
  regfile_mp_sb_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) bus_b ();

  regfile_mp_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );

  regfile_mp_sb #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wren;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        alloc_en;
    logic [4:0]  alloc_addr;
    logic        flush;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic        e_b0;
    logic        e_b1;
    logic [5:0]  e_cnt;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic addVec(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                        input logic a, input logic [4:0] aa, input logic f,
                        input logic [4:0] r0, input logic [4:0] r1,
                        input logic [31:0] e0, input logic [31:0] e1,
                        input logic b0, input logic b1, input logic [5:0] c);
    vec_t v;
    v.wren = w; v.waddr = wa; v.wdata = wd;
    v.alloc_en = a; v.alloc_addr = aa; v.flush = f;
    v.ra0 = r0; v.ra1 = r1;
    v.e_rd0 = e0; v.e_rd1 = e1; v.e_b0 = b0; v.e_b1 = b1; v.e_cnt = c;
    vecs.push_back(v);
  endtask

  task automatic pushExp(input string name, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic checkOutput(input logic [31:0] act);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_underflow: got %h with nothing expected", act);
    end else begin
      e = sb_q.pop_front();
      if (act !== e.exp) begin
        errors++;
        $display("[TB] FAIL %s: got %h, expected %h", e.name, act, e.exp);
      end
    end
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    bus_a.wren       = v.wren;
    bus_a.waddr      = v.waddr;
    bus_a.wdata      = v.wdata;
    bus_a.alloc_en   = v.alloc_en;
    bus_a.alloc_addr = v.alloc_addr;
    bus_a.flush      = v.flush;
    bus_a.raddr      = {v.ra1, v.ra0};
    pushExp($sformatf("v%0d.rdata0", idx), v.e_rd0);
    pushExp($sformatf("v%0d.rdata1", idx), v.e_rd1);
    pushExp($sformatf("v%0d.rbusy", idx), {30'd0, v.e_b1, v.e_b0});
    pushExp($sformatf("v%0d.busy_cnt", idx), {26'd0, v.e_cnt});
  endtask

  initial begin
    rst_n = 1'b0;
    bus_a.raddr = '0; bus_a.wren = 0; bus_a.waddr = '0; bus_a.wdata = '0;
    bus_a.alloc_en = 0; bus_a.alloc_addr = '0; bus_a.flush = 0;
    bus_b.raddr = '0; bus_b.wren = 0; bus_b.waddr = '0; bus_b.wdata = '0;
    bus_b.alloc_en = 0; bus_b.alloc_addr = '0; bus_b.flush = 0;

    #1;
    pushExp("init.busy_cnt", 32'd0);
    checkOutput({26'd0, bus_a.busy_cnt});
    pushExp("init.rdata0", 32'd0);
    checkOutput(bus_a.rdata[31:0]);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //      wren wa  wdata         alloc aa  fl  ra0 ra1 e_rd0         e_rd1         b0 b1 cnt
    addVec(1, 5, 32'hDEADBEEF,   0, 0,  0,  5,  0, 32'hDEADBEEF, 32'h0,        0, 0, 0);
    addVec(0, 0, 32'h0,          0, 0,  0,  5,  5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
    addVec(1, 0, 32'h00001234,   0, 0,  0,  0,  5, 32'h0,        32'hDEADBEEF, 0, 0, 0);
    addVec(0, 0, 32'h0,          1, 3,  0,  0,  3, 32'h0,        32'h0,        0, 0, 1);
    addVec(0, 0, 32'h0,          0, 0,  0,  3,  5, 32'h0,        32'hDEADBEEF, 1, 0, 1);
    addVec(1, 3, 32'h00000033,   0, 0,  0,  3,  3, 32'h33,       32'h33,       0, 0, 0);
    addVec(1, 3, 32'h00000044,   1, 3,  0,  3,  6, 32'h44,       32'h0,        0, 0, 1);
    addVec(0, 0, 32'h0,          0, 0,  0,  3,  0, 32'h44,       32'h0,        1, 0, 1);
    addVec(0, 0, 32'h0,          1, 0,  0,  0,  3, 32'h0,        32'h44,       0, 1, 1);
    addVec(1, 7, 32'hA5A5A5A5,   0, 0,  0,  4,  7, 32'h0,        32'hA5A5A5A5, 0, 0, 1);
    addVec(1, 3, 32'h00000044,   1, 1,  0,  3,  1, 32'h44,       32'h0,        0, 0, 1);
    addVec(0, 0, 32'h0,          1, 2,  0,  1,  2, 32'h0,        32'h0,        1, 0, 2);
    addVec(0, 0, 32'h0,          1, 4,  0,  5,  7, 32'hDEADBEEF, 32'hA5A5A5A5, 0, 0, 3);
    addVec(0, 0, 32'h0,          1, 9,  1,  4,  9, 32'h0,        32'h0,        1, 0, 1);
    addVec(0, 0, 32'h0,          0, 0,  0,  9,  1, 32'h0,        32'h0,        1, 0, 1);
    addVec(0, 0, 32'h0,          0, 0,  0,  5,  3, 32'hDEADBEEF, 32'h44,       0, 0, 1);
    addVec(0, 0, 32'h0,          1, 9,  0,  9,  2, 32'h0,        32'h0,        1, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(i, vecs[i]);
      #1;
      checkOutput(bus_a.rdata[31:0]);
      checkOutput(bus_a.rdata[63:32]);
      checkOutput({30'd0, bus_a.rbusy});
      @(posedge clk);
      #1;
      checkOutput({26'd0, bus_a.busy_cnt});
    end

    // Mid-operation reset with a write and alloc in flight: both must be discarded.
    @(negedge clk);
    bus_a.wren = 1; bus_a.waddr = 5'd5; bus_a.wdata = 32'hCAFEF00D;
    bus_a.alloc_en = 1; bus_a.alloc_addr = 5'd9; bus_a.flush = 0;
    bus_a.raddr = {5'd1, 5'd9};
    #2 rst_n = 1'b0;
    #1;
    pushExp("rst.busy_cnt", 32'd0);
    checkOutput({26'd0, bus_a.busy_cnt});
    pushExp("rst.rbusy", 32'd0);
    checkOutput({30'd0, bus_a.rbusy});
    @(posedge clk);
    #1;
    bus_a.wren = 0; bus_a.alloc_en = 0;
    for (int a = 0; a < 32; a++) begin
      bus_a.raddr = {a[4:0], a[4:0]};
      #1;
      pushExp($sformatf("rst.r%0d", a), 32'd0);
      checkOutput(bus_a.rdata[31:0]);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Narrow variant: r0 writable, no bypass, every register allocatable.
    @(negedge clk);
    bus_b.raddr = {3'd3, 3'd2, 3'd1, 3'd0};
    bus_b.wren = 1; bus_b.waddr = 3'd0; bus_b.wdata = 16'h1111;
    #1;
    pushExp("b.r0_pre_edge", 32'd0);
    checkOutput({16'd0, bus_b.rdata[15:0]});
    @(posedge clk);
    #1;
    pushExp("b.r0_post_edge", 32'h1111);
    checkOutput({16'd0, bus_b.rdata[15:0]});

    @(negedge clk);
    bus_b.raddr = {3'd7, 3'd2, 3'd1, 3'd0};
    bus_b.waddr = 3'd7; bus_b.wdata = 16'hBEEF;
    #1;
    pushExp("b.r7_pre_edge", 32'd0);
    checkOutput({16'd0, bus_b.rdata[63:48]});
    @(posedge clk);
    #1;
    pushExp("b.r7_post_edge", 32'hBEEF);
    checkOutput({16'd0, bus_b.rdata[63:48]});

    @(negedge clk);
    bus_b.wren = 0;
    for (int i = 0; i < 8; i++) begin
      bus_b.alloc_en = 1; bus_b.alloc_addr = i[2:0];
      @(posedge clk);
      #1;
      pushExp($sformatf("b.alloc%0d.busy_cnt", i), i + 1);
      checkOutput({28'd0, bus_b.busy_cnt});
      @(negedge clk);
    end
    bus_b.alloc_en = 0;
    bus_b.raddr = {3'd7, 3'd6, 3'd1, 3'd0};
    #1;
    pushExp("b.all_busy", 32'hF);
    checkOutput({28'd0, bus_b.rbusy});

    @(negedge clk);
    bus_b.wren = 1; bus_b.waddr = 3'd7; bus_b.wdata = 16'h7777;
    #1;
    pushExp("b.r7_busy_pre_edge", 32'hF);
    checkOutput({28'd0, bus_b.rbusy});
    @(posedge clk);
    #1;
    pushExp("b.r7_busy_post_edge", 32'h7);
    checkOutput({28'd0, bus_b.rbusy});
    pushExp("b.busy_cnt_after_write", 32'd7);
    checkOutput({28'd0, bus_b.busy_cnt});

    @(negedge clk);
    bus_b.wren = 0; bus_b.flush = 1;
    @(posedge clk);
    #1;
    pushExp("b.flush.busy_cnt", 32'd0);
    checkOutput({28'd0, bus_b.busy_cnt});
    pushExp("b.flush.r0_kept", 32'h1111);
    checkOutput({16'd0, bus_b.rdata[15:0]});
    @(negedge clk);
    bus_b.flush = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
